// File: rtl/aes_cbc_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one iterative AES-CBC core between
// NUM_CH AXI-Stream requesters. Datapaths are pure muxes; only control is registered.
module aes_cbc_stream_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int AXIS_WIDTH = 64,
    localparam int ID_W      = $clog2(NUM_CH),
    localparam int KW        = AXIS_WIDTH / 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_CH-1:0]            S_axis_tvalid,
    output logic [NUM_CH-1:0]            S_axis_tready,
    input  logic [NUM_CH*AXIS_WIDTH-1:0] S_axis_tdata,
    input  logic [NUM_CH*KW-1:0]         S_axis_tkeep,
    input  logic [NUM_CH-1:0]            S_axis_tlast,
    input  logic [NUM_CH-1:0]            S_axis_tuser,
    output logic                         Core_s_tvalid,
    input  logic                         Core_s_tready,
    output logic [AXIS_WIDTH-1:0]        Core_s_tdata,
    output logic [KW-1:0]                Core_s_tkeep,
    output logic                         Core_s_tlast,
    output logic                         Core_s_tuser,
    input  logic                         Core_m_tvalid,
    output logic                         Core_m_tready,
    input  logic [AXIS_WIDTH-1:0]        Core_m_tdata,
    input  logic [KW-1:0]                Core_m_tkeep,
    input  logic                         Core_m_tlast,
    output logic                         M_axis_tvalid,
    input  logic                         M_axis_tready,
    output logic [AXIS_WIDTH-1:0]        M_axis_tdata,
    output logic [KW-1:0]                M_axis_tkeep,
    output logic                         M_axis_tlast,
    output logic [ID_W-1:0]              M_axis_tdest,
    output logic                         Grant_valid,
    output logic [ID_W-1:0]              Grant_id
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    logic            state_r;
    logic [ID_W-1:0] grant_id_r;
    logic [ID_W-1:0] last_grant_r;
    logic            in_done_r;

    logic            active_s;
    logic            found_s;
    logic [ID_W-1:0] pick_s;
    logic            in_last_acc_s;
    logic            out_last_acc_s;

    assign active_s = (state_r == ST_ACTIVE);

    // Round-robin search starting just after the previous owner
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (int'(last_grant_r) + k) % NUM_CH;
            if (!found_s && S_axis_tvalid[idx]) begin
                found_s = 1'b1;
                pick_s  = ID_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Input path: owner's stream to the core; stalls once its tlast has gone in
    always_comb begin
        S_axis_tready = '0;
        Core_s_tvalid = 1'b0;
        Core_s_tdata  = '0;
        Core_s_tkeep  = '0;
        Core_s_tlast  = 1'b0;
        Core_s_tuser  = 1'b0;
        if (active_s) begin
            S_axis_tready[grant_id_r] = Core_s_tready & ~in_done_r;
            Core_s_tvalid = S_axis_tvalid[grant_id_r] & ~in_done_r;
            if (Core_s_tvalid) begin
                Core_s_tdata = S_axis_tdata[int'(grant_id_r)*AXIS_WIDTH +: AXIS_WIDTH];
                Core_s_tkeep = S_axis_tkeep[int'(grant_id_r)*KW +: KW];
                Core_s_tlast = S_axis_tlast[grant_id_r];
                Core_s_tuser = S_axis_tuser[grant_id_r];
            end else begin
                Core_s_tdata = '0;
            end
        end else begin
            S_axis_tready = '0;
        end
    end

    // Output path: core results tagged with the owner; blocked while idle
    always_comb begin
        Core_m_tready = 1'b0;
        M_axis_tvalid = 1'b0;
        M_axis_tdata  = '0;
        M_axis_tkeep  = '0;
        M_axis_tlast  = 1'b0;
        M_axis_tdest  = '0;
        if (active_s) begin
            Core_m_tready = M_axis_tready;
            M_axis_tvalid = Core_m_tvalid;
            if (Core_m_tvalid) begin
                M_axis_tdata = Core_m_tdata;
                M_axis_tkeep = Core_m_tkeep;
                M_axis_tlast = Core_m_tlast;
                M_axis_tdest = grant_id_r;
            end else begin
                M_axis_tdata = '0;
            end
        end else begin
            Core_m_tready = 1'b0;
        end
    end

    assign in_last_acc_s  = Core_s_tvalid & Core_s_tready & Core_s_tlast;
    assign out_last_acc_s = M_axis_tvalid & M_axis_tready & M_axis_tlast;
    assign Grant_valid    = active_s;
    assign Grant_id       = active_s ? grant_id_r : '0;

    // Ownership FSM: packet ends when the core's tlast beat leaves
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= ST_IDLE;
            grant_id_r   <= '0;
            last_grant_r <= ID_W'(NUM_CH - 1);
            in_done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_id_r   <= pick_s;
                        last_grant_r <= pick_s;
                        in_done_r    <= 1'b0;
                        state_r      <= ST_ACTIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (in_last_acc_s) begin
                        in_done_r <= 1'b1;
                    end else begin
                        in_done_r <= in_done_r;
                    end
                    if (out_last_acc_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_stream_arbiter.sv
// Directed bench for aes_cbc_stream_arbiter with a behavioural stand-in for the
// AES core (data blocks XOR-masked by direction, emitted after the input tlast).
module tb_aes_cbc_stream_arbiter;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic [3:0]   s_vld = '0, s_last = '0, s_user = '0;
    logic [3:0]   s_rdy;
    logic [255:0] s_data = '0;
    logic [31:0]  s_keep = 32'hFFFF_FFFF;
    logic         c_s_vld, c_s_rdy, c_s_last, c_s_user;
    logic [63:0]  c_s_data;
    logic [7:0]   c_s_keep;
    logic         c_m_vld, c_m_rdy, c_m_last;
    logic [63:0]  c_m_data;
    logic         M_axis_tvalid, M_axis_tready, M_axis_tlast, Grant_valid;
    logic [63:0]  M_axis_tdata;
    logic [7:0]   M_axis_tkeep;
    logic [1:0]   M_axis_tdest, Grant_id;

    bit   rand_mode = 1'b0, gaps = 1'b0, drv_to = 1'b0;
    logic rnd_m = 1'b1, rnd_c = 1'b1;
    assign M_axis_tready = rand_mode ? rnd_m : 1'b1;
    assign c_s_rdy       = rand_mode ? rnd_c : 1'b1;

    aes_cbc_stream_arbiter #(.NUM_CH(4), .AXIS_WIDTH(64)) dut (
        .Clk(Clk), .Rst(Rst),
        .S_axis_tvalid(s_vld), .S_axis_tready(s_rdy), .S_axis_tdata(s_data),
        .S_axis_tkeep(s_keep), .S_axis_tlast(s_last), .S_axis_tuser(s_user),
        .Core_s_tvalid(c_s_vld), .Core_s_tready(c_s_rdy), .Core_s_tdata(c_s_data),
        .Core_s_tkeep(c_s_keep), .Core_s_tlast(c_s_last), .Core_s_tuser(c_s_user),
        .Core_m_tvalid(c_m_vld), .Core_m_tready(c_m_rdy), .Core_m_tdata(c_m_data),
        .Core_m_tkeep(8'hFF), .Core_m_tlast(c_m_last),
        .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(M_axis_tready), .M_axis_tdata(M_axis_tdata),
        .M_axis_tkeep(M_axis_tkeep), .M_axis_tlast(M_axis_tlast), .M_axis_tdest(M_axis_tdest),
        .Grant_valid(Grant_valid), .Grant_id(Grant_id)
    );

    function automatic logic [63:0] xf(input logic [63:0] d, input logic usr);
        return usr ? (d ^ 64'hFFFF_FFFF_0000_0000) : (d ^ 64'h0000_0000_FFFF_FFFF);
    endfunction

    // Beats 0-3 key 00..1f, 4-5 IV 0, then data; seeds 0/1 carry the reference PT/CT
    function automatic logic [63:0] beat_val(input int seed, input int b);
        logic [63:0] v;
        case (b)
            0: v = 64'h0001_0203_0405_0607;
            1: v = 64'h0809_0A0B_0C0D_0E0F;
            2: v = 64'h1011_1213_1415_1617;
            3: v = 64'h1819_1A1B_1C1D_1E1F;
            4, 5: v = 64'h0;
            6: v = (seed == 0) ? 64'h0011_2233_4455_6677 : 64'h8EA2_B7CA_5167_45BF;
            7: v = (seed == 0) ? 64'h8899_AABB_CCDD_EEFF : 64'hEAFC_4990_4B49_6089;
            default: v = 64'h0;
        endcase
        if (seed >= 2) v = {32'(seed), 32'(b)};
        return v;
    endfunction

    // Core stand-in: collects data beats, replays them masked after input tlast
    logic [63:0] c_mem [32];
    logic [7:0]  c_cnt = 8'd0;
    logic [4:0]  c_wr = 5'd0, c_rd = 5'd0;
    logic        c_done = 1'b0, c_mode = 1'b0;
    assign c_m_vld  = c_done && (c_rd != c_wr);
    assign c_m_last = ((c_rd + 5'd1) == c_wr);
    assign c_m_data = xf(c_mem[c_rd], c_mode);

    always @(posedge Clk) begin
        rnd_m <= 1'($urandom_range(0, 1));
        rnd_c <= 1'($urandom_range(0, 1));
        if (Rst) begin
            c_cnt <= 8'd0; c_wr <= 5'd0; c_rd <= 5'd0; c_done <= 1'b0;
        end else begin
            if (c_s_vld && c_s_rdy) begin
                if (c_cnt == 8'd0) c_mode <= c_s_user;
                c_cnt <= c_cnt + 8'd1;
                if (c_cnt >= 8'd6) begin
                    c_mem[c_wr] <= c_s_data;
                    c_wr <= c_wr + 5'd1;
                end
                if (c_s_last) c_done <= 1'b1;
            end
            if (c_m_vld && c_m_rdy) begin
                c_rd <= c_rd + 5'd1;
                if (c_m_last) begin
                    c_done <= 1'b0; c_cnt <= 8'd0; c_wr <= 5'd0; c_rd <= 5'd0;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [63:0] cap_d[$];
    logic [1:0]  cap_t[$];
    logic        cap_l[$];
    logic [1:0]  gq[$];
    logic        gv_prev = 1'b0;
    int          viol = 0, leak = 0;

    // Result, grant and protocol-violation monitor
    always @(negedge Clk) begin
        if (M_axis_tvalid && M_axis_tready) begin
            cap_d.push_back(M_axis_tdata);
            cap_t.push_back(M_axis_tdest);
            cap_l.push_back(M_axis_tlast);
        end
        if (Grant_valid && !gv_prev) gq.push_back(Grant_id);
        gv_prev <= Grant_valid;
        if (c_done && c_s_vld && c_s_rdy) viol <= viol + 1;
        for (int i = 0; i < 4; i++)
            if (s_rdy[i] && !(Grant_valid && int'(Grant_id) == i)) leak <= leak + 1;
    end

    int n_tests = 0, n_fail = 0;

    task automatic send_pkt(input int ch, input logic usr, input int nblk, input int seed,
                            input int stop_after);
        int   b = 0;
        int   nb = 6 + 2 * nblk;
        int   budget = 0;
        logic hs;
        while (b < nb && b != stop_after) begin
            s_vld[ch] = !(gaps && $urandom_range(0, 2) == 0);
            s_data[ch*64 +: 64] = beat_val(seed, b);
            s_last[ch] = (b == nb - 1);
            s_user[ch] = usr;
            @(negedge Clk);
            hs = s_vld[ch] & s_rdy[ch];
            @(posedge Clk); #1;
            if (hs) b++;
            budget++;
            if (budget > 3000) begin drv_to = 1'b1; break; end
        end
        s_vld[ch] = 1'b0;
        s_last[ch] = 1'b0;
    endtask

    task automatic wait_caps(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge Clk); #1;
            if (cap_d.size() >= target) begin ok = 1'b1; break; end
        end
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge Clk);
        n_tests++; if (Grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b expected 0", Grant_valid); end
        n_tests++; if (s_rdy !== 4'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b expected 0000", s_rdy); end
        n_tests++; if ({c_s_vld, c_m_rdy, M_axis_tvalid} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b expected 000", {c_s_vld, c_m_rdy, M_axis_tvalid}); end
        n_tests++; if ({c_s_data, M_axis_tdest} !== 66'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", {c_s_data, M_axis_tdest}); end
        @(posedge Clk); #1;
    endtask

    task automatic test_single_enc();
        int base = cap_d.size();
        bit ok;
        send_pkt(0, 1'b1, 1, 0, -1);
        wait_caps(base + 2, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL enc_timeout: got %0d beats expected 2", cap_d.size() - base); return; end
        n_tests++; if (cap_d[base] !== 64'hFFEE_DDCC_4455_6677) begin n_fail++; $display("FAIL enc_beat0: got %h expected ffeeddcc44556677", cap_d[base]); end
        n_tests++; if (cap_d[base+1] !== 64'h7766_5544_CCDD_EEFF) begin n_fail++; $display("FAIL enc_beat1: got %h expected 77665544ccddeeff", cap_d[base+1]); end
        n_tests++; if ({cap_t[base], cap_t[base+1]} !== 4'b0000) begin n_fail++; $display("FAIL enc_tdest: got %b expected 0000", {cap_t[base], cap_t[base+1]}); end
        n_tests++; if ({cap_l[base], cap_l[base+1]} !== 2'b01) begin n_fail++; $display("FAIL enc_tlast: got %b expected 01", {cap_l[base], cap_l[base+1]}); end
    endtask

    task automatic test_decrypt_ch2();
        int base = cap_d.size();
        bit ok;
        send_pkt(2, 1'b0, 1, 1, -1);
        wait_caps(base + 2, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL dec_timeout: got %0d beats expected 2", cap_d.size() - base); return; end
        n_tests++; if (cap_d[base] !== 64'h8EA2_B7CA_AE98_BA40) begin n_fail++; $display("FAIL dec_beat0: got %h expected 8ea2b7caae98ba40", cap_d[base]); end
        n_tests++; if (cap_d[base+1] !== 64'hEAFC_4990_B4B6_9F76) begin n_fail++; $display("FAIL dec_beat1: got %h expected eafc4990b4b69f76", cap_d[base+1]); end
        n_tests++; if ({cap_t[base], cap_t[base+1]} !== 4'b1010) begin n_fail++; $display("FAIL dec_tdest: got %b expected 1010", {cap_t[base], cap_t[base+1]}); end
    endtask

    task automatic test_round_robin();
        int   ech[5] = '{0, 1, 2, 3, 0};
        logic eu[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   es[5]  = '{100, 101, 102, 103, 104};
        int   base, gbase;
        bit   ok;
        do_reset();
        base = cap_d.size();
        gbase = gq.size();
        fork
            begin send_pkt(0, 1'b1, 1, 100, -1); send_pkt(0, 1'b1, 1, 104, -1); end
            send_pkt(1, 1'b0, 1, 101, -1);
            send_pkt(2, 1'b1, 1, 102, -1);
            send_pkt(3, 1'b0, 1, 103, -1);
        join
        wait_caps(base + 10, ok);
        n_tests++;
        if (!ok || gq.size() < gbase + 5) begin n_fail++; $display("FAIL rr_timeout: got %0d beats %0d grants expected 10 5", cap_d.size() - base, gq.size() - gbase); return; end
        for (int j = 0; j < 5; j++) begin
            n_tests++; if (gq[gbase+j] !== 2'(ech[j])) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", j, gq[gbase+j], ech[j]); end
            for (int b = 0; b < 2; b++) begin
                n_tests++;
                if (cap_d[base+2*j+b] !== xf(beat_val(es[j], 6 + b), eu[j]) || cap_t[base+2*j+b] !== 2'(ech[j])) begin
                    n_fail++;
                    $display("FAIL rr_data[%0d.%0d]: got %h/%0d expected %h/%0d", j, b, cap_d[base+2*j+b], cap_t[base+2*j+b], xf(beat_val(es[j], 6 + b), eu[j]), ech[j]);
                end
            end
        end
        n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL rr_in_done: got %0d beats after tlast expected 0", viol); end
    endtask

    task automatic test_back_to_back();
        int base = cap_d.size();
        int out1_cyc = -100, rdy3_cyc = -1;
        bit seen = 1'b0, ok;
        fork
            send_pkt(1, 1'b1, 2, 40, -1);
            begin
                for (int k = 0; k < 200 && !(Grant_valid && Grant_id == 2'd1); k++) @(negedge Clk);
                @(posedge Clk); #1;
                send_pkt(3, 1'b0, 1, 41, -1);
            end
            begin
                for (int k = 0; k < 3000 && !seen; k++) begin
                    @(negedge Clk);
                    if (M_axis_tvalid && M_axis_tready && M_axis_tlast && M_axis_tdest == 2'd1) out1_cyc = cyc;
                    if (s_rdy[3]) begin rdy3_cyc = cyc; seen = 1'b1; end
                end
            end
        join
        wait_caps(base + 6, ok);
        n_tests++; if (rdy3_cyc - out1_cyc != 2) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles expected 2", rdy3_cyc - out1_cyc); end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d beats expected 6", cap_d.size() - base); return; end
        n_tests++; if (cap_d[base+3] !== xf(beat_val(40, 9), 1'b1) || cap_t[base+3] !== 2'd1) begin n_fail++; $display("FAIL b2b_ch1: got %h/%0d expected %h/1", cap_d[base+3], cap_t[base+3], xf(beat_val(40, 9), 1'b1)); end
        n_tests++; if (cap_d[base+5] !== xf(beat_val(41, 7), 1'b0) || cap_t[base+5] !== 2'd3) begin n_fail++; $display("FAIL b2b_ch3: got %h/%0d expected %h/3", cap_d[base+5], cap_t[base+5], xf(beat_val(41, 7), 1'b0)); end
        n_tests++; if (leak !== 0) begin n_fail++; $display("FAIL b2b_ready_leak: got %0d expected 0", leak); end
    endtask

    task automatic test_random_cbc();
        int base = cap_d.size();
        bit ok;
        rand_mode = 1'b1; gaps = 1'b1;
        send_pkt(2, 1'b1, 3, 30, -1);
        wait_caps(base + 6, ok);
        rand_mode = 1'b0; gaps = 1'b0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rand_timeout: got %0d beats expected 6", cap_d.size() - base); return; end
        for (int b = 0; b < 6; b++) begin
            n_tests++;
            if (cap_d[base+b] !== xf(beat_val(30, 6 + b), 1'b1) || cap_t[base+b] !== 2'd2 || cap_l[base+b] !== (b == 5)) begin
                n_fail++;
                $display("FAIL rand_beat[%0d]: got %h/%0d/%b expected %h/2/%b", b, cap_d[base+b], cap_t[base+b], cap_l[base+b], xf(beat_val(30, 6 + b), 1'b1), b == 5);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        send_pkt(1, 1'b1, 1, 50, 5);
        @(negedge Clk);
        n_tests++; if (Grant_valid !== 1'b1 || Grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_owner: got %b/%0d expected 1/1", Grant_valid, Grant_id); end
        @(posedge Clk); #1 Rst = 1'b1;
        @(posedge Clk); #1 Rst = 1'b0;
        @(negedge Clk);
        n_tests++; if (Grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_grant: got %b expected 0", Grant_valid); end
        n_tests++; if ({s_rdy, c_m_rdy} !== 5'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 00000", {s_rdy, c_m_rdy}); end
        @(posedge Clk); #1;
        base = cap_d.size();
        send_pkt(1, 1'b0, 1, 51, -1);
        wait_caps(base + 2, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mid_timeout: got %0d beats expected 2", cap_d.size() - base); return; end
        for (int b = 0; b < 2; b++) begin
            n_tests++;
            if (cap_d[base+b] !== xf(beat_val(51, 6 + b), 1'b0) || cap_t[base+b] !== 2'd1) begin
                n_fail++;
                $display("FAIL mid_fresh[%0d]: got %h/%0d expected %h/1", b, cap_d[base+b], cap_t[base+b], xf(beat_val(51, 6 + b), 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_enc();
        test_decrypt_ch2();
        test_round_robin();
        test_back_to_back();
        test_random_cbc();
        test_reset_mid();
        n_tests++; if (drv_to !== 1'b0) begin n_fail++; $display("FAIL driver_timeout: got %b expected 0", drv_to); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
